// File: rtl/axi_master_pkg.sv
// Shared definitions for the memory-controller AXI-lite-burst interface:
// width defaults, master FSM encoding and the len/beats convention.
package axi_master_pkg;

    localparam int DEF_ADDR_WIDTH         = 20;
    localparam int DEF_DATA_WIDTH         = 64;
    localparam int DEF_LEN_WIDTH          = 6;
    localparam int DEF_MAX_RD_OUTSTANDING = 4;

    // A burst carries len + LEN_TO_BEATS beats.
    localparam int LEN_TO_BEATS = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_AR   = 2'd3
    } mst_state_e;

    function automatic int len_to_beats(input int len);
        return len + LEN_TO_BEATS;
    endfunction

endpackage

// File: rtl/axi_master_len_fifo.sv
// Show-ahead FIFO of outstanding read-burst lengths; the head is the
// length of the burst whose R beats are currently arriving.
module axi_master_len_fifo
    import axi_master_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_RD_OUTSTANDING,
    parameter int WIDTH = DEF_LEN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_len,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_len;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axi_master.sv
// Burst initiator: single-word commands become AW/W or AR bursts; R beats
// are tracked against the queued burst lengths and returned registered.
module axi_master
    import axi_master_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int AXI_DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int AXI_LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int MAX_RD_OUTSTANDING = DEF_MAX_RD_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
    input  logic                      usr_wvalid,
    output logic                      usr_wready,
    input  logic [AXI_DATA_WIDTH-1:0] usr_wdata,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic                      axi_wlast,
    output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    input  logic                      axi_rvalid,
    input  logic                      axi_rlast,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    output logic                      usr_rvalid,
    output logic                      usr_rlast,
    output logic [AXI_DATA_WIDTH-1:0] usr_rdata,
    output logic                      wr_done,
    output logic                      rd_done,
    output logic                      busy,
    output logic                      rlast_err,
    output logic [1:0]                state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; a valid, once raised, holds with stable
    // addr/len/last/data until that edge.

    localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;

    mst_state_e                state;
    mst_state_e                state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [AXI_LEN_WIDTH-1:0]  aw_len_q;
    logic [AXI_LEN_WIDTH-1:0]  ar_len_q;
    logic [AXI_LEN_WIDTH-1:0]  beat;
    logic [AXI_LEN_WIDTH-1:0]  rbeat;
    logic [AXI_LEN_WIDTH-1:0]  q_head;
    logic [CNT_W-1:0]          rd_out;
    logic                      rd_full;
    logic                      q_empty;
    logic                      cmd_acc;
    logic                      aw_acc;
    logic                      w_acc;
    logic                      ar_acc;
    logic                      r_exp_last;
    logic                      r_pop;

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_wdata   = '0;
        usr_wready  = 1'b0;
        axi_arvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !rd_full && !rst;
                if (cmd_valid && cmd_ready) state_nxt = cmd_wr ? ST_AW : ST_AR;
            end
            ST_AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready) state_nxt = ST_W;
            end
            ST_W: begin
                axi_wvalid = usr_wvalid;
                usr_wready = axi_wready;
                axi_wdata  = usr_wdata;
                axi_wlast  = (beat == aw_len_q);
                if (usr_wvalid && axi_wready && axi_wlast) state_nxt = ST_IDLE;
            end
            ST_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_acc = cmd_valid && cmd_ready;
    assign aw_acc  = axi_awvalid && axi_awready;
    assign w_acc   = axi_wvalid && axi_wready;
    assign ar_acc  = axi_arvalid && axi_arready;

    // Burst end is decided by the local count; axi_rlast is only checked.
    assign r_exp_last = !q_empty && (rbeat == q_head);
    assign r_pop      = axi_rvalid && r_exp_last;

    axi_master_len_fifo #(
        .DEPTH (MAX_RD_OUTSTANDING),
        .WIDTH (AXI_LEN_WIDTH)
    ) u_len_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ar_acc),
        .push_len (ar_len_q),
        .pop      (r_pop),
        .head     (q_head),
        .full     (rd_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            beat       <= '0;
            rbeat      <= '0;
            rd_out     <= '0;
            wr_done    <= 1'b0;
            rd_done    <= 1'b0;
            usr_rvalid <= 1'b0;
            usr_rlast  <= 1'b0;
            usr_rdata  <= '0;
            rlast_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                if (cmd_wr) begin
                    aw_addr_q <= cmd_addr;
                    aw_len_q  <= cmd_len;
                end else begin
                    ar_addr_q <= cmd_addr;
                    ar_len_q  <= cmd_len;
                end
            end
            if (aw_acc)     beat <= '0;
            else if (w_acc) beat <= beat + AXI_LEN_WIDTH'(1);
            wr_done <= w_acc && axi_wlast;

            usr_rvalid <= axi_rvalid;
            usr_rlast  <= axi_rlast;
            usr_rdata  <= axi_rdata;
            rd_done    <= r_pop;
            if (axi_rvalid && !q_empty) rbeat <= r_exp_last ? '0 : rbeat + AXI_LEN_WIDTH'(1);
            if (axi_rvalid && (q_empty || (axi_rlast != r_exp_last))) rlast_err <= 1'b1;

            // Issue and completion in the same cycle cancel out.
            case ({ar_acc, r_pop})
                2'b10:   rd_out <= rd_out + CNT_W'(1);
                2'b01:   rd_out <= rd_out - CNT_W'(1);
                default: rd_out <= rd_out;
            endcase
        end
    end

    assign axi_awaddr = aw_addr_q;
    assign axi_awlen  = aw_len_q;
    assign axi_araddr = ar_addr_q;
    assign axi_arlen  = ar_len_q;
    assign busy       = (state != ST_IDLE) || (rd_out != '0);
    assign state_dbg  = state;

endmodule
